ram_io_responder: RTL and testbench
===================================

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 17, meaning byte-address bits decoded for RAM (128 KiB).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per IO FIFO (power of two).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; it is synchronous and active-low.
REQ-005 SHALL have port rdy, input, 1, meaning global enable; when low, all state is frozen.
REQ-006 SHALL have port ram_ena, input, 1, meaning a memory request is present this cycle.
REQ-007 SHALL have port wr_mc2ram, input, 1, meaning direction: 1 = write, 0 = read.
REQ-008 SHALL have port addr_2ram, input, 32, meaning byte address.
REQ-009 SHALL have port data_2ram, input, 8, meaning write byte.
REQ-010 SHALL have port data_from_ram, output, 8, meaning registered read byte.
REQ-011 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1), meaning the outbound IO byte stream.
REQ-012 SHALL have ports rx_data (input, 8), rx_valid (input, 1) and rx_ready (output, 1), meaning the inbound IO byte stream.
REQ-013 SHALL have ports io_full (output, 1), tx_overflow (output, 1) and program_done (output, 1).

Function
REQ-014 SHALL decode as follows: addr_2ram[17:16]==2'b11 selects IO space; otherwise RAM index is addr_2ram[RAM_ADDR_WIDTH-1:0].
REQ-015 SHALL, for a RAM write (ram_ena=1, wr=1, rdy=1), update mem[index] with data_2ram at that edge.
REQ-016 SHALL, for a read request in cycle N, drive data_from_ram in cycle N+1 (latency exactly 1); the byte address may change every cycle for back-to-back reads.
REQ-017 SHALL hold data_from_ram unchanged in cycles with no read request.
REQ-018 SHALL push data_2ram into the TX FIFO on an IO write to 0x30000; if the FIFO is full and no pop occurs that cycle, the byte SHALL be dropped and sticky tx_overflow set.
REQ-019 SHALL accept a push to a full TX FIFO when a pop occurs in the same cycle.
REQ-020 SHALL set sticky program_done on an IO write to 0x30004; data is ignored.
REQ-021 SHALL return {7'b0, tx_empty} on an IO read of 0x30004, and 0x00 on reads of any other IO address except 0x30000.
REQ-022 SHALL drive tx_valid = TX FIFO non-empty, with tx_data = head; pop when tx_valid and tx_ready; tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-023 SHALL drive io_full = TX FIFO full (combinational from count).
REQ-024 SHALL treat IO writes to other addresses as no-ops.
REQ-025 SHALL, when rdy=0, update no state and ignore the ram, tx and rx handshakes (no push or pop).
REQ-026 SHALL order FIFOs FIFO-wise and maintain count 0..FIFO_DEPTH with pointer wrap modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, while rst=0 at an edge, clear data_from_ram, tx_overflow and program_done, empty both FIFOs (tx_valid=0, io_full=0, rx_ready=1 if present), and leave RAM contents unchanged.
REQ-028 SHALL, on reset mid-stream, discard queued bytes and abort any pending read result.

Configuration
REQ-029 SHALL implement the RX path when IO_RX_EN is defined: RX FIFO, rx_ready = not full, push on rx_valid&&rx_ready, and an IO read of 0x30000 pops and returns the head, or returns 0x00 with no pop if empty.
REQ-030 SHALL, when IO_RX_EN is undefined, have no RX FIFO: rx_ready tied 0, rx_data ignored, and reads of 0x30000 return 0x00.

Structure
REQ-031 SHALL place IO_BASE (0x30000), IO_CTRL (0x30004) and the byte-width constants in the shared const package.
REQ-032 SHALL implement the FIFO as one sub-module, sync_byte_fifo, instantiated for TX and optionally for RX.

Verification
REQ-033 SHALL cover: write 0xA5 to 0x00010, then read 0x00010 -> data_from_ram=0xA5 exactly one cycle after the read request.
REQ-034 SHALL cover: reads of 0x00000..0x00003 on consecutive cycles holding bytes 0x13,0x05,0x00,0x00 -> outputs in that order at N+1..N+4.
REQ-035 SHALL cover: 9 writes to 0x30000 with tx_ready=0 -> io_full after the 8th and tx_overflow=1 after the 9th; then tx_ready=1 -> the 8 bytes are emitted in order.
REQ-036 SHALL cover: a write to 0x30004 -> program_done=1 next cycle and staying set until rst=0.
REQ-037 SHALL cover: with IO_RX_EN, rx bytes 0x41,0x42 -> reads of 0x30000 return 0x41, 0x42, then 0x00.
REQ-038 SHALL cover: rdy=0 during a write to 0x00020 -> memory unchanged and data_from_ram held.

Source files
------------

// File: rtl/ram_io_responder_pkg.sv
// ---------------------------------------------------------------------------
// ram_io_responder_pkg
// Shared constants and types for the RAM/IO responder.
//   BYTE_W / ADDR_W : byte and address widths
//   IO_BASE         : IO data port (TX push on write, RX pop on read)
//   IO_CTRL         : IO control (write sets program_done, read gives status)
//   acc_kind_e      : classification of a request address
//   decode_addr()   : address -> acc_kind_e
// ---------------------------------------------------------------------------
package ram_io_responder_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 32;

    // IO space is selected by address bits [17:16] == 2'b11; IO register
    // matches compare the low IO_DEC_W address bits.
    localparam int IO_SEL_LSB = 16;
    localparam int IO_DEC_W   = 18;

    localparam logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000;
    localparam logic [ADDR_W-1:0] IO_CTRL = 32'h0003_0004;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ACC_RAM      = 2'd0,
        ACC_IO_DATA  = 2'd1,
        ACC_IO_CTRL  = 2'd2,
        ACC_IO_OTHER = 2'd3
    } acc_kind_e;

    function automatic acc_kind_e decode_addr(input logic [ADDR_W-1:0] addr);
        acc_kind_e kind;
        if (addr[IO_DEC_W-1:IO_SEL_LSB] != 2'b11) begin
            kind = ACC_RAM;
        end else if (addr[IO_DEC_W-1:0] == IO_BASE[IO_DEC_W-1:0]) begin
            kind = ACC_IO_DATA;
        end else if (addr[IO_DEC_W-1:0] == IO_CTRL[IO_DEC_W-1:0]) begin
            kind = ACC_IO_CTRL;
        end else begin
            kind = ACC_IO_OTHER;
        end
        return kind;
    endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// ---------------------------------------------------------------------------
// ram_io_responder_if
// Memory request bus plus the outbound (TX) and inbound (RX) byte streams
// and the status flags of the RAM/IO responder.
//   slave  : the responder (ram_io_responder)
//   master : the requester / stream peers (processor side, testbench)
// Signals:
//   ram_ena, wr_mc2ram, addr_2ram, data_2ram, data_from_ram : memory bus
//   tx_data, tx_valid, tx_ready                             : TX stream
//   rx_data, rx_valid, rx_ready                             : RX stream
//   io_full, tx_overflow, program_done                      : status
// ---------------------------------------------------------------------------
interface ram_io_responder_if;
    import ram_io_responder_pkg::*;

    logic              ram_ena;
    logic              wr_mc2ram;
    logic [ADDR_W-1:0] addr_2ram;
    byte_t             data_2ram;
    byte_t             data_from_ram;

    byte_t             tx_data;
    logic              tx_valid;
    logic              tx_ready;

    byte_t             rx_data;
    logic              rx_valid;
    logic              rx_ready;

    logic              io_full;
    logic              tx_overflow;
    logic              program_done;

    modport slave (
        input  ram_ena, wr_mc2ram, addr_2ram, data_2ram,
        input  tx_ready, rx_data, rx_valid,
        output data_from_ram, tx_data, tx_valid, rx_ready,
        output io_full, tx_overflow, program_done
    );

    modport master (
        output ram_ena, wr_mc2ram, addr_2ram, data_2ram,
        output tx_ready, rx_data, rx_valid,
        input  data_from_ram, tx_data, tx_valid, rx_ready,
        input  io_full, tx_overflow, program_done
    );

endinterface

// File: rtl/ram_io_responder_fifo.sv
// ---------------------------------------------------------------------------
// sync_byte_fifo
// Single-clock byte FIFO with first-word-fall-through head output.
// Ports:
//   clk_i     : clock (rising edge)
//   rst_i     : synchronous reset, active low; empties the FIFO
//   push_i    : write request; accepted when not full, or when full and a
//               pop happens in the same cycle
//   pop_i     : read request; ignored when empty
//   wdata_i   : byte to write
//   rdata_o   : head byte (valid while empty_o = 0)
//   empty_o   : no entries
//   full_o    : DEPTH entries
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_byte_fifo
    import ram_io_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push_i,
    input  logic  pop_i,
    input  byte_t wdata_i,
    output byte_t rdata_o,
    output logic  empty_o,
    output logic  full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    byte_t             mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (rst_i && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// ---------------------------------------------------------------------------
// ram_io_responder
// Byte-wide RAM plus a small memory-mapped IO block behind one request bus.
//   addr[17:16] != 2'b11 : RAM, index addr[RAM_ADDR_WIDTH-1:0]
//   0x30000 write        : push byte into TX FIFO (dropped + tx_overflow
//                          when full and not popping this cycle)
//   0x30000 read         : RX FIFO head with pop (0x00 when empty or when
//                          the RX path is not built)
//   0x30004 write        : set program_done (data ignored)
//   0x30004 read         : {7'b0, tx_empty}
//   other IO             : writes ignored, reads return 0x00
// Read data is registered: one cycle latency, held when no read is issued.
// rdy = 0 freezes all state and ignores every handshake.
// Ports:
//   clk  : clock (rising edge)
//   rst  : synchronous reset, active low; RAM contents are preserved
//   rdy  : global enable
//   bus  : ram_io_responder_if.slave (memory bus, TX/RX streams, status)
// Build option:
//   IO_RX_EN : when defined, instantiates the RX FIFO and its read port.
// ---------------------------------------------------------------------------
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    ram_io_responder_if.slave     bus
);

    localparam int RAM_BYTES = 1 << RAM_ADDR_WIDTH;

    byte_t mem_q [RAM_BYTES];

    byte_t data_from_ram_q, data_from_ram_d;
    logic  tx_overflow_q,   tx_overflow_d;
    logic  program_done_q,  program_done_d;

    acc_kind_e                 kind;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      wr_req;
    logic                      rd_req;
    logic                      ram_we;

    logic  tx_push_req;
    logic  tx_pop;
    logic  tx_empty;
    logic  tx_full;
    byte_t tx_head;

    logic  rx_empty;
    byte_t rx_head;
    logic  rx_pop;

    assign kind    = decode_addr(bus.addr_2ram);
    assign ram_idx = bus.addr_2ram[RAM_ADDR_WIDTH-1:0];
    assign wr_req  = rdy && bus.ram_ena && bus.wr_mc2ram;
    assign rd_req  = rdy && bus.ram_ena && !bus.wr_mc2ram;
    assign ram_we  = wr_req && (kind == ACC_RAM);

    // ---------------------------------------------------------------- TX path
    assign tx_push_req = wr_req && (kind == ACC_IO_DATA);
    assign tx_pop      = rdy && !tx_empty && bus.tx_ready;

    sync_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (tx_push_req),
        .pop_i   (tx_pop),
        .wdata_i (bus.data_2ram),
        .rdata_o (tx_head),
        .empty_o (tx_empty),
        .full_o  (tx_full)
    );

    assign bus.tx_data  = tx_head;
    assign bus.tx_valid = !tx_empty;
    assign bus.io_full  = tx_full;

    // ---------------------------------------------------------------- RX path
`ifdef IO_RX_EN
    logic rx_full;
    logic rx_push;

    assign rx_push = rdy && bus.rx_valid && !rx_full;
    assign rx_pop  = rd_req && (kind == ACC_IO_DATA) && !rx_empty;

    sync_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (bus.rx_data),
        .rdata_o (rx_head),
        .empty_o (rx_empty),
        .full_o  (rx_full)
    );

    assign bus.rx_ready = !rx_full;
`else
    logic unused_rx;

    assign rx_empty     = 1'b1;
    assign rx_head      = '0;
    assign rx_pop       = 1'b0;
    assign unused_rx    = ^{bus.rx_data, bus.rx_valid, rx_pop};
    assign bus.rx_ready = 1'b0;
`endif

    // -------------------------------------------------------- read / status
    always_comb begin
        data_from_ram_d = data_from_ram_q;
        tx_overflow_d   = tx_overflow_q;
        program_done_d  = program_done_q;

        if (rd_req) begin
            unique case (kind)
                ACC_RAM:     data_from_ram_d = mem_q[ram_idx];
                ACC_IO_DATA: data_from_ram_d = rx_empty ? '0 : rx_head;
                ACC_IO_CTRL: data_from_ram_d = {{(BYTE_W-1){1'b0}}, tx_empty};
                default:     data_from_ram_d = '0;
            endcase
        end

        // A push into a full FIFO survives only if a pop frees a slot now.
        if (tx_push_req && tx_full && !tx_pop) begin
            tx_overflow_d = 1'b1;
        end

        if (wr_req && (kind == ACC_IO_CTRL)) begin
            program_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_from_ram_q <= '0;
            tx_overflow_q   <= 1'b0;
            program_done_q  <= 1'b0;
        end else begin
            data_from_ram_q <= data_from_ram_d;
            tx_overflow_q   <= tx_overflow_d;
            program_done_q  <= program_done_d;
        end
    end

    // RAM array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (rst && ram_we) begin
            mem_q[ram_idx] <= bus.data_2ram;
        end
    end

    assign bus.data_from_ram = data_from_ram_q;
    assign bus.tx_overflow   = tx_overflow_q;
    assign bus.program_done  = program_done_q;

endmodule

// File: tb/tb_ram_io_responder.sv
module tb_ram_io_responder;
    import ram_io_responder_pkg::*;

`ifdef IO_RX_EN
    localparam logic RX_READY_RST = 1'b1;
`else
    localparam logic RX_READY_RST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    ram_io_responder_if bus();

    ram_io_responder #(
        .RAM_ADDR_WIDTH (17),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    int    total = 0;
    int    bad   = 0;
    byte_t rd_q [$];
    byte_t tx_q [$];
    byte_t model_mem [int];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ram_ena   = 1'b0;
        bus.wr_mc2ram = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input byte_t data);
        bus.ram_ena   = 1'b1;
        bus.wr_mc2ram = 1'b1;
        bus.addr_2ram = addr;
        bus.data_2ram = data;
        if (rdy && rst && addr[17:16] != 2'b11) begin
            model_mem[int'(addr[16:0])] = data;
        end
        step();
        idle();
    endtask

    // Issue one read cycle; the expected byte is queued now and compared
    // once the registered result appears.
    task automatic rd_issue(input logic [31:0] addr, input byte_t exp);
        bus.ram_ena   = 1'b1;
        bus.wr_mc2ram = 1'b0;
        bus.addr_2ram = addr;
        rd_q.push_back(exp);
        step();
    endtask

    task automatic rd_check(input string tag);
        if (rd_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
        end else begin
            chk(tag, bus.data_from_ram, rd_q.pop_front());
        end
    endtask

    task automatic drain_tx(input string tag);
        bus.tx_ready = 1'b1;
        for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
            if (bus.tx_valid) begin
                chk(tag, bus.tx_data, tx_q.pop_front());
            end
            step();
        end
        chk({tag, "_left"}, 8'(tx_q.size()), 8'd0);
        chk({tag, "_valid_end"}, 8'(bus.tx_valid), 8'd0);
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        rdy           = 1'b1;
        bus.ram_ena   = 1'b0;
        bus.wr_mc2ram = 1'b0;
        bus.addr_2ram = '0;
        bus.data_2ram = '0;
        bus.tx_ready  = 1'b0;
        bus.rx_data   = '0;
        bus.rx_valid  = 1'b0;
        step();
        step();

        chk("rst_data",     bus.data_from_ram, 8'h00);
        chk("rst_tx_valid", 8'(bus.tx_valid), 8'd0);
        chk("rst_io_full",  8'(bus.io_full), 8'd0);
        chk("rst_overflow", 8'(bus.tx_overflow), 8'd0);
        chk("rst_done",     8'(bus.program_done), 8'd0);
        chk("rst_rx_ready", 8'(bus.rx_ready), 8'(RX_READY_RST));
        rst = 1'b1;
        step();

        // Write then read back with one cycle latency, then hold.
        wr(32'h10, 8'hA5);
        rd_issue(32'h10, model_mem[32'h10]);
        idle();
        rd_check("rd_a5");
        step();
        chk("hold_a5", bus.data_from_ram, 8'hA5);

        // Back-to-back reads with changing address.
        wr(32'h0, 8'h13);
        wr(32'h1, 8'h05);
        wr(32'h2, 8'h00);
        wr(32'h3, 8'h00);
        for (int i = 0; i < 4; i++) begin
            rd_issue(32'(i), model_mem[i]);
            rd_check($sformatf("b2b_%0d", i));
        end
        idle();

        // rdy = 0 freezes memory and the read register.
        wr(32'h20, 8'h11);
        rd_issue(32'h10, model_mem[32'h10]);
        idle();
        rd_check("pre_freeze");
        rdy = 1'b0;
        wr(32'h20, 8'h77);
        chk("freeze_wr_hold", bus.data_from_ram, 8'hA5);
        rd_issue(32'h20, 8'hA5);
        idle();
        rd_check("freeze_rd_hold");
        rdy = 1'b1;
        rd_issue(32'h20, model_mem[32'h20]);
        idle();
        rd_check("mem_unchanged");

        // TX: fill to full, overflow on the ninth write, stable head.
        for (int i = 0; i < 9; i++) begin
            wr(32'h30000, 8'(8'h60 + i));
            if (i < 8) tx_q.push_back(8'(8'h60 + i));
            chk($sformatf("io_full_%0d", i), 8'(bus.io_full), 8'(i >= 7));
            chk($sformatf("ovf_%0d", i), 8'(bus.tx_overflow), 8'(i == 8));
            chk($sformatf("tx_head_%0d", i), bus.tx_data, 8'h60);
        end
        rd_issue(32'h30004, 8'h00);
        idle();
        rd_check("status_busy");
        drain_tx("tx_order");
        chk("io_full_drained", 8'(bus.io_full), 8'd0);
        chk("ovf_sticky", 8'(bus.tx_overflow), 8'd1);
        rd_issue(32'h30004, 8'h01);
        idle();
        rd_check("status_empty");

        // program_done is sticky; other IO addresses do nothing.
        wr(32'h30004, 8'hFF);
        chk("done_set", 8'(bus.program_done), 8'd1);
        step();
        step();
        step();
        chk("done_sticky", 8'(bus.program_done), 8'd1);
        wr(32'h30008, 8'h55);
        chk("io_other_wr", 8'(bus.tx_valid), 8'd0);
        rd_issue(32'h30008, 8'h00);
        idle();
        rd_check("io_other_rd");

        // RX path.
`ifdef IO_RX_EN
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h41;
        step();
        bus.rx_data  = 8'h42;
        step();
        bus.rx_valid = 1'b0;
        rd_issue(32'h30000, 8'h41);
        rd_check("rx_0");
        rd_issue(32'h30000, 8'h42);
        rd_check("rx_1");
        rd_issue(32'h30000, 8'h00);
        rd_check("rx_empty");
        idle();
`else
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h41;
        step();
        chk("rx_ready_off", 8'(bus.rx_ready), 8'd0);
        bus.rx_valid = 1'b0;
        rd_issue(32'h30000, 8'h00);
        idle();
        rd_check("rx_off_rd");
`endif

        // Reset mid-stream: queued TX bytes and a pending read are dropped.
        wr(32'h30000, 8'hC1);
        wr(32'h30000, 8'hC2);
        wr(32'h30000, 8'hC3);
        chk("pre_rst_valid", 8'(bus.tx_valid), 8'd1);
        rst           = 1'b0;
        bus.ram_ena   = 1'b1;
        bus.wr_mc2ram = 1'b0;
        bus.addr_2ram = 32'h10;
        step();
        idle();
        chk("rst_abort_rd", bus.data_from_ram, 8'h00);
        chk("rst_tx_flush", 8'(bus.tx_valid), 8'd0);
        chk("rst_done_clr", 8'(bus.program_done), 8'd0);
        chk("rst_ovf_clr",  8'(bus.tx_overflow), 8'd0);
        rst = 1'b1;
        step();
        rd_issue(32'h10, model_mem[32'h10]);
        idle();
        rd_check("ram_kept");

        // Push into a full FIFO is accepted when a pop happens in the same cycle.
        for (int i = 0; i < 8; i++) begin
            wr(32'h30000, 8'(8'h80 + i));
            tx_q.push_back(8'(8'h80 + i));
        end
        chk("full_again", 8'(bus.io_full), 8'd1);
        bus.tx_ready = 1'b1;
        chk("pop_push_head", bus.tx_data, tx_q.pop_front());
        tx_q.push_back(8'h99);
        wr(32'h30000, 8'h99);
        bus.tx_ready = 1'b0;
        chk("pop_push_full", 8'(bus.io_full), 8'd1);
        chk("pop_push_no_ovf", 8'(bus.tx_overflow), 8'd0);
        drain_tx("tx_pp_order");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
